// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_fetch_queue
// Brief    : DEPTH-entry {PC, instruction} FIFO between fetch and decode with
//            valid/ready handshakes on both sides. A taken branch/jump
//            (PCSrc) flushes every entry. Empty/flushed queue presents NOP.
// Option   : IF_ID_FETCHQ_BYPASS_EN - when defined, an offer arriving at an
//            empty queue is presented to decode in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCSrc,
  input  logic                       IF_valid,
  output logic                       IF_ready,
  input  logic [XLEN-1:0]            PC_IF,
  input  logic [XLEN-1:0]            INSTRUCTION_IF,
  input  logic                       ID_ready,
  output logic                       ID_valid,
  output logic [XLEN-1:0]            PC_ID,
  output logic [XLEN-1:0]            INSTRUCTION_ID,
  output logic [$clog2(DEPTH):0]     LEVEL
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              LW         = AW + 1;
  localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);

  // Each entry holds {PC, instruction}
  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     level;

  logic empty;
  logic bypass_hit;
  logic push_en;
  logic pop_en;

  assign empty    = (level == '0);
  assign IF_ready = (level != FULL_LEVEL);
  assign LEVEL    = level;

`ifdef IF_ID_FETCHQ_BYPASS_EN
  // Offer goes straight to decode while the queue is empty (held off in reset)
  assign bypass_hit = reset & empty & IF_valid & ~PCSrc;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed offer that decode takes immediately is never stored
  assign push_en = IF_valid & IF_ready & ~PCSrc & ~(bypass_hit & ID_ready);
  // Only stored entries are popped; a bypassed entry never touches rd_ptr
  assign pop_en  = ~empty & ID_ready & ~PCSrc;

  // Head-entry presentation: stored head, bypassed offer, or NOP when idle
  always_comb begin
    ID_valid       = ~empty | bypass_hit;
    PC_ID          = '0;
    INSTRUCTION_ID = NOP_INSTR;
    if (!empty) begin
      PC_ID          = mem[rd_ptr][2*XLEN-1:XLEN];
      INSTRUCTION_ID = mem[rd_ptr][XLEN-1:0];
    end else if (bypass_hit) begin
      PC_ID          = PC_IF;
      INSTRUCTION_ID = INSTRUCTION_IF;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= {PC_IF, INSTRUCTION_IF};
    end
  end

  // Pointers and occupancy; flush outranks any push or pop in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (PCSrc) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire
